// File: rtl/maple_xfer_sequencer.sv
// Maple Bus host transaction sequencer: runs one TX packet, turns the bus
// around, opens a bounded RX response window and reports how it ended.
module maple_xfer_sequencer #(
  parameter int C_TIMEOUT_WIDTH = 20,
  parameter int C_TX_GUARD      = 1024,
  parameter int C_TURNAROUND    = 16
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       expect_response,
  input  logic [C_TIMEOUT_WIDTH-1:0] timeout_cycles,
  input  logic                       tx_pending,
  input  logic                       transmitting,
  input  logic                       receiving,
  input  logic                       rx_last,
  output logic                       enable_tx,
  output logic                       enable_rx,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic                       error,
  output logic                       aborted,
  output logic [2:0]                 state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TX_WAIT   = 3'd1,
    S_TX_ACTIVE = 3'd2,
    S_TURN      = 3'd3,
    S_RX_WAIT   = 3'd4,
    S_RX_ACTIVE = 3'd5
  } state_t;

  // One sequence counter is shared by the TX guard and the turnaround timer.
  localparam int GW = $clog2(C_TX_GUARD + 1);
  localparam int TW = $clog2(C_TURNAROUND + 1);
  localparam int SW = (GW > TW) ? GW : TW;
  localparam logic [SW-1:0] GUARD_LAST = SW'(C_TX_GUARD - 1);
  localparam logic [SW-1:0] TURN_LAST  = SW'(C_TURNAROUND - 1);
  localparam logic [SW-1:0] SEQ_ONE    = SW'(1);
  localparam logic [C_TIMEOUT_WIDTH-1:0] WIN_ONE = C_TIMEOUT_WIDTH'(1);

  state_t                     state_q, state_n;
  logic [SW-1:0]              seq_cnt_q, seq_cnt_n;
  logic [C_TIMEOUT_WIDTH-1:0] win_cnt_q, win_cnt_n;
  logic [C_TIMEOUT_WIDTH-1:0] tmo_q, tmo_n;
  logic                       exp_rsp_q, exp_rsp_n;
  logic                       abort_pend_q, abort_pend_n;
  logic                       tx_q, rx_q;
  logic                       enable_tx_n, enable_rx_n, busy_n;
  logic                       done_n, timeout_n, error_n, aborted_n;
  logic                       tx_fall, rx_fall;

  assign tx_fall = tx_q & ~transmitting;
  assign rx_fall = rx_q & ~receiving;
  assign state   = state_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= S_IDLE;
      seq_cnt_q    <= '0;
      win_cnt_q    <= '0;
      tmo_q        <= '0;
      exp_rsp_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      tx_q         <= 1'b0;
      rx_q         <= 1'b0;
      enable_tx    <= 1'b0;
      enable_rx    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      error        <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state_q      <= state_n;
      seq_cnt_q    <= seq_cnt_n;
      win_cnt_q    <= win_cnt_n;
      tmo_q        <= tmo_n;
      exp_rsp_q    <= exp_rsp_n;
      abort_pend_q <= abort_pend_n;
      tx_q         <= transmitting;
      rx_q         <= receiving;
      enable_tx    <= enable_tx_n;
      enable_rx    <= enable_rx_n;
      busy         <= busy_n;
      done         <= done_n;
      timeout      <= timeout_n;
      error        <= error_n;
      aborted      <= aborted_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    seq_cnt_n    = seq_cnt_q;
    win_cnt_n    = win_cnt_q;
    tmo_n        = tmo_q;
    exp_rsp_n    = exp_rsp_q;
    abort_pend_n = abort_pend_q;
    done_n       = 1'b0;
    timeout_n    = 1'b0;
    error_n      = 1'b0;
    aborted_n    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (tx_pending) begin
            state_n      = S_TX_WAIT;
            seq_cnt_n    = '0;
            exp_rsp_n    = expect_response;
            tmo_n        = timeout_cycles;
            abort_pend_n = 1'b0;
          end else begin
            error_n = 1'b1;
          end
        end
      end
      S_TX_WAIT: begin
        if (abort) begin
          state_n   = S_IDLE;
          aborted_n = 1'b1;
        end else if (transmitting) begin
          state_n = S_TX_ACTIVE;
        end else if (seq_cnt_q == GUARD_LAST) begin
          state_n = S_IDLE;
          error_n = 1'b1;
        end else begin
          seq_cnt_n = seq_cnt_q + SEQ_ONE;
        end
      end
      S_TX_ACTIVE: begin
        // A packet in flight is never cut short; the abort waits for its end.
        if (tx_fall) begin
          if (abort_pend_q || abort) begin
            state_n   = S_IDLE;
            aborted_n = 1'b1;
          end else begin
            state_n   = S_TURN;
            seq_cnt_n = '0;
          end
          abort_pend_n = 1'b0;
        end else if (abort) begin
          abort_pend_n = 1'b1;
        end
      end
      S_TURN: begin
        if (abort) begin
          state_n   = S_IDLE;
          aborted_n = 1'b1;
        end else if (seq_cnt_q == TURN_LAST) begin
          if (exp_rsp_q) begin
            state_n   = S_RX_WAIT;
            win_cnt_n = tmo_q;
          end else begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end else begin
          seq_cnt_n = seq_cnt_q + SEQ_ONE;
        end
      end
      S_RX_WAIT: begin
        if (abort) begin
          state_n   = S_IDLE;
          aborted_n = 1'b1;
        end else if (receiving) begin
          state_n = S_RX_ACTIVE;
        end else if (win_cnt_q == '0) begin
          state_n   = S_IDLE;
          timeout_n = 1'b1;
        end else begin
          win_cnt_n = win_cnt_q - WIN_ONE;
        end
      end
      S_RX_ACTIVE: begin
        if (abort) begin
          state_n   = S_IDLE;
          aborted_n = 1'b1;
        end else if (rx_last) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else if (rx_fall) begin
          state_n = S_IDLE;
          error_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    enable_tx_n = (state_n == S_TX_WAIT) || (state_n == S_TX_ACTIVE);
    enable_rx_n = (state_n == S_RX_WAIT) || (state_n == S_RX_ACTIVE);
    busy_n      = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_maple_xfer_sequencer.sv
// Directed bench for maple_xfer_sequencer: timing checks in the main thread,
// terminal pulses matched against an expected queue by a monitor.
module tb_maple_xfer_sequencer;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start, abort, expect_response;
  logic [19:0] timeout_cycles;
  logic        tx_pending, transmitting, receiving, rx_last;
  logic        enable_tx, enable_rx, busy, done, timeout, error, aborted;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;
  int rx_hi    = 0;
  logic [3:0] exp_q[$];  // {done, timeout, error, aborted}

  localparam logic [3:0] P_DONE    = 4'b1000;
  localparam logic [3:0] P_TIMEOUT = 4'b0100;
  localparam logic [3:0] P_ERROR   = 4'b0010;
  localparam logic [3:0] P_ABORTED = 4'b0001;

  maple_xfer_sequencer dut (
    .aclk            (aclk),
    .areset          (areset),
    .start           (start),
    .abort           (abort),
    .expect_response (expect_response),
    .timeout_cycles  (timeout_cycles),
    .tx_pending      (tx_pending),
    .transmitting    (transmitting),
    .receiving       (receiving),
    .rx_last         (rx_last),
    .enable_tx       (enable_tx),
    .enable_rx       (enable_rx),
    .busy            (busy),
    .done            (done),
    .timeout         (timeout),
    .error           (error),
    .aborted         (aborted),
    .state           (state)
  );

  always #5 aclk = ~aclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic start_txn(input logic rsp, input logic [19:0] tmo);
    start           = 1'b1;
    expect_response = rsp;
    timeout_cycles  = tmo;
    tick(1);
    start = 1'b0;
  endtask

  // Drives one packet from TX_WAIT; returns with the fall just sampled.
  task automatic send_packet(input int hi_cycles);
    transmitting = 1'b1;
    tick(hi_cycles);
    transmitting = 1'b0;
    tick(1);
  endtask

  task automatic wait_rx_en(output int n);
    n = 0;
    while (!enable_rx && n < 200) begin
      tick(1);
      n++;
    end
    check("rx_en_seen", {31'b0, enable_rx}, 1);
  endtask

  // Monitor: enable overlap, RX enable activity, terminal pulse scoreboard.
  always @(posedge aclk) begin
    logic [3:0] pulses;
    #1;
    if (enable_tx && enable_rx) overlap++;
    if (enable_rx) rx_hi++;
    pulses = {done, timeout, error, aborted};
    if (pulses != 4'b0) begin
      if (exp_q.size() == 0) check("unexpected_pulse", {28'b0, pulses}, 0);
      else                   check("pulse", {28'b0, pulses}, {28'b0, exp_q.pop_front()});
    end
  end

  initial begin
    int n;
    int rx_before;
    areset = 1'b1; start = 1'b0; abort = 1'b0; expect_response = 1'b0;
    timeout_cycles = '0; tx_pending = 1'b0; transmitting = 1'b0;
    receiving = 1'b0; rx_last = 1'b0;
    tick(3);
    check("reset_outputs", {25'b0, enable_tx, enable_rx, busy, done, timeout, error, aborted}, 0);
    check("reset_state", {29'b0, state}, 0);
    areset = 1'b0;
    tick(1);

    // Normal transaction with response
    tx_pending = 1'b1;
    exp_q.push_back(P_DONE);
    start_txn(1'b1, 20'd100);
    check("s1_busy_entx", {30'b0, busy, enable_tx}, 3);
    check("s1_state_txwait", {29'b0, state}, 1);
    tick(3);
    transmitting = 1'b1;
    tick(1);
    check("s1_state_txactive", {29'b0, state}, 2);
    tick(49);
    transmitting = 1'b0;
    tick(1);
    check("s1_state_turn", {29'b0, state}, 3);
    check("s1_entx_low", {31'b0, enable_tx}, 0);
    wait_rx_en(n);
    check("s1_turn_gap", n, 16);
    check("s1_state_rxwait", {29'b0, state}, 4);
    tick(19);
    receiving = 1'b1;
    tick(1);
    check("s1_state_rxactive", {29'b0, state}, 5);
    tick(29);
    rx_last = 1'b1;
    tick(1);
    rx_last = 1'b0;
    receiving = 1'b0;
    check("s1_done", {29'b0, done, busy, enable_rx}, 4);
    check("s1_state_idle", {29'b0, state}, 0);
    tick(1);
    check("s1_done_one_cycle", {31'b0, done}, 0);

    // No response: timeout window = timeout_cycles + 1
    exp_q.push_back(P_TIMEOUT);
    start_txn(1'b1, 20'd10);
    tick(2);
    send_packet(5);
    wait_rx_en(n);
    n = 0;
    while (!timeout && n < 50) begin
      tick(1);
      n++;
    end
    check("s2_timeout_delay", n, 11);
    check("s2_enrx_low", {31'b0, enable_rx}, 0);
    check("s2_state_idle", {29'b0, state}, 0);
    tick(1);

    // Command only, then immediate restart on the done cycle
    rx_before = rx_hi;
    exp_q.push_back(P_DONE);
    start_txn(1'b0, 20'd0);
    send_packet(8);
    check("s3_state_turn", {29'b0, state}, 3);
    n = 0;
    while (!done && n < 50) begin
      tick(1);
      n++;
    end
    check("s3_done_after_turn", n, 16);
    exp_q.push_back(P_DONE);
    start_txn(1'b0, 20'd0);
    check("s3_restart_busy", {30'b0, busy, enable_tx}, 3);
    send_packet(3);
    n = 0;
    while (!done && n < 50) begin
      tick(1);
      n++;
    end
    check("s3_restart_done", n, 16);
    check("s3_no_enrx", rx_hi - rx_before, 0);
    tick(1);

    // Abort during TX_ACTIVE: deferred to the end of the packet
    exp_q.push_back(P_ABORTED);
    start_txn(1'b1, 20'd50);
    transmitting = 1'b1;
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("s4a_still_txactive", {28'b0, aborted, state}, 2);
    tick(5);
    transmitting = 1'b0;
    tick(1);
    check("s4a_aborted", {28'b0, aborted, state}, 8);
    tick(1);

    // Abort during RX_WAIT: immediate
    exp_q.push_back(P_ABORTED);
    start_txn(1'b1, 20'd100);
    send_packet(4);
    wait_rx_en(n);
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("s4b_aborted", {27'b0, aborted, enable_rx, state}, 16);
    tick(1);

    // Start with empty TX FIFO
    tx_pending = 1'b0;
    exp_q.push_back(P_ERROR);
    start_txn(1'b1, 20'd5);
    check("s5a_error_idle", {28'b0, error, busy, state[1:0]}, 8);
    tick(1);
    check("s5a_error_one_cycle", {31'b0, error}, 0);
    tx_pending = 1'b1;

    // Transmitter never starts: guard expiry
    exp_q.push_back(P_ERROR);
    start_txn(1'b1, 20'd5);
    n = 0;
    while (!error && n < 1100) begin
      tick(1);
      n++;
    end
    check("s5b_guard_cycles", n, 1024);
    check("s5b_state_idle", {29'b0, state}, 0);
    tick(1);

    // Receiver drops without tlast
    exp_q.push_back(P_ERROR);
    start_txn(1'b1, 20'd30);
    send_packet(4);
    wait_rx_en(n);
    receiving = 1'b1;
    tick(4);
    receiving = 1'b0;
    tick(1);
    check("s5c_error", {28'b0, error, state}, 8);
    tick(1);

    // receiving rises exactly on the counter-zero cycle; start while busy
    exp_q.push_back(P_DONE);
    start_txn(1'b1, 20'd5);
    send_packet(4);
    wait_rx_en(n);
    tick(5);
    receiving = 1'b1;
    tick(1);
    check("s6a_rxactive_not_timeout", {28'b0, timeout, state}, 5);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("s6b_start_ignored", {29'b0, state}, 5);
    rx_last = 1'b1;
    tick(1);
    rx_last = 1'b0;
    receiving = 1'b0;
    check("s6a_done", {28'b0, done, state}, 8);
    tick(3);
    check("s6b_no_queued_start", {31'b0, busy}, 0);

    // Reset in the middle of RX_ACTIVE
    start_txn(1'b1, 20'd40);
    send_packet(4);
    wait_rx_en(n);
    receiving = 1'b1;
    tick(2);
    check("s6c_pre_reset_state", {29'b0, state}, 5);
    areset = 1'b1;
    tick(1);
    check("s6c_reset_outputs", {25'b0, enable_tx, enable_rx, busy, done, timeout, error, aborted}, 0);
    check("s6c_reset_state", {29'b0, state}, 0);
    areset = 1'b0;
    receiving = 1'b0;
    tick(3);

    check("enables_never_overlap", overlap, 0);
    check("all_pulses_seen", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maple_xfer_sequencer.md
# maple_xfer_sequencer

Host-side transaction sequencer for one Maple Bus port. It sits between the AXI-Lite control registers and the transmitter/receiver pair, and drives their `ENABLE` inputs. On a start request it runs one command packet out of the TX FIFO, turns the bus around, and opens a bounded response window for the receiver. It reports done, timeout, error or abort, so software never toggles the TX/RX enables by hand.

## Interface
Parameters:
- `C_TIMEOUT_WIDTH`, default 20: width of the response-window counter and of `timeout_cycles`.
- `C_TX_GUARD`, default 1024: maximum cycles in TX_WAIT for `transmitting` to rise before an error.
- `C_TURNAROUND`, default 16: cycles with both enables low between TX end and RX enable (≥1).

Ports:
- `aclk` in 1: single clock. All logic is on its rising edge.
- `areset` in 1: reset, synchronous, active-high.
- `start` in 1: pulse; begins a transaction. Honoured only in IDLE.
- `abort` in 1: pulse; cancels the current transaction.
- `expect_response` in 1: sampled on an accepted `start`; 1 means run the RX phase.
- `timeout_cycles` in C_TIMEOUT_WIDTH: response window, sampled on an accepted `start`.
- `tx_pending` in 1: TX FIFO holds at least one complete packet (TX packet count ≠ 0).
- `transmitting` in 1: from the transmitter.
- `receiving` in 1: from the receiver.
- `rx_last` in 1: RX handshake beat with tlast (tvalid & tready & tlast at the receiver output).
- `enable_tx` out 1: drives transmitter `ENABLE`.
- `enable_rx` out 1: drives receiver `ENABLE`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; transaction completed normally.
- `timeout` out 1: one-cycle pulse; no response started within the window.
- `error` out 1: one-cycle pulse; protocol fault (see Operation).
- `aborted` out 1: one-cycle pulse; transaction cancelled by `abort`.
- `state` out 3: current state encoding, for debug and status readback.

## Operation
State encodings: IDLE=0, TX_WAIT=1, TX_ACTIVE=2, TURN=3, RX_WAIT=4, RX_ACTIVE=5.

Transitions:
- **IDLE**
  - `start` & `tx_pending` → TX_WAIT. `expect_response` and `timeout_cycles` are latched.
  - `start` & !`tx_pending` → `error` pulse; stay in IDLE.
- **TX_WAIT** (`enable_tx`=1; guard counter runs)
  - `transmitting` = 1 → TX_ACTIVE.
  - Guard counter reaches C_TX_GUARD → `error` pulse, then IDLE.
- **TX_ACTIVE** (`enable_tx`=1)
  - `transmitting` falls → TURN.
- **TURN** (both enables 0; lasts exactly C_TURNAROUND cycles)
  - At the end, if latched `expect_response` = 1 → RX_WAIT.
  - Otherwise → `done` pulse, then IDLE.
- **RX_WAIT** (`enable_rx`=1)
  - The down-counter is loaded with latched `timeout_cycles` on entry.
  - `receiving` = 1 → RX_ACTIVE.
  - Counter = 0 with `receiving` = 0 → `timeout` pulse, then IDLE.
  - The counter decrements each cycle otherwise, so the window is `timeout_cycles`+1 cycles.
- **RX_ACTIVE** (`enable_rx`=1)
  - `rx_last` → `done` pulse, then IDLE.
  - `receiving` falls with no `rx_last` seen → `error` pulse, then IDLE.

Abort:
- In TX_WAIT, TURN, RX_WAIT or RX_ACTIVE: next state is IDLE with an `aborted` pulse.
- In TX_ACTIVE: a sticky abort flag is set. The packet finishes, and when `transmitting` falls the block goes to IDLE with `aborted` instead of TURN.
- In IDLE: ignored; no pulse.

Priority within one cycle:
- `abort` > `rx_last` > `receiving` edge > timeout/guard expiry.
- In RX_WAIT, `receiving` = 1 in the same cycle the counter is 0 goes to RX_ACTIVE, not timeout.
- `rx_last` in the same cycle `receiving` falls counts as `done`.

Other rules:
- `start` while `busy` is dropped and not queued.
- At most one of `done`/`timeout`/`error`/`aborted` pulses per transaction.
- `transmitting` falling is detected against a registered previous value. `rx_last` is level-sampled.

## Timing
- All outputs are registered.
- Reset: `state`=IDLE, all outputs 0, counters 0, abort flag 0. Reset mid-transaction drops both enables on the next edge; the TX FIFO and receiver are left to their own resets.
- `start` accepted at edge N → `busy`=1 and `enable_tx`=1 from N+1.
- `transmitting` rises at edge M → state=TX_ACTIVE from M+1.
- `transmitting` falls at edge M → `enable_tx`=0 and state=TURN from M+1. `enable_rx` = 1 from M+1+C_TURNAROUND.
- Terminal pulses are high for exactly the cycle in which state returns to IDLE. `busy` = 0 in that same cycle.
- `start` accepted on the cycle after a terminal pulse (back-to-back transactions, no bubble required).

## Test plan
1. Normal transaction:
   - Stimulus: `tx_pending`=1, start, `expect_response`=1, `timeout_cycles`=100. `transmitting` is high for 50 cycles. `receiving` rises 20 cycles after `enable_rx`. `rx_last` follows after 30 cycles.
   - Required response: `done` pulse only. `enable_tx` and `enable_rx` are never high together. The gap between them is exactly 16 cycles.
2. No response:
   - Stimulus: `timeout_cycles`=10; `receiving` stays 0.
   - Required response: `timeout` pulse exactly 11 cycles after `enable_rx` rises; `enable_rx` low on the same cycle.
3. Command only:
   - Stimulus: `expect_response`=0.
   - Required response: `done` at the end of TURN; `enable_rx` never asserted.
4. Abort:
   - Abort during TX_ACTIVE → `aborted` pulse only after `transmitting` falls; no TURN state.
   - Abort during RX_WAIT → `aborted` on the next cycle.
5. Faults:
   - start with `tx_pending`=0 → single `error` pulse; `busy` stays 0.
   - `transmitting` never rises → `error` after 1024 cycles.
   - `receiving` falls without `rx_last` → `error`.
6. Corner cases:
   - `receiving` rises on the counter=0 cycle → RX_ACTIVE, no timeout.
   - `start` during `busy` → ignored.
   - `areset` mid-RX_ACTIVE → all outputs 0 on the next edge.
   - Immediate restart after `done` → accepted.
